// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one byte-enabled write port and one read port on a single clock,
// with selectable read-during-write behaviour, optional output register and post-reset clear.
module dual_port_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    busy
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned NB    = DATA_WIDTH / 8;

    typedef enum logic {StInit, StRun} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_be;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    // The init sweep owns the write port, so user traffic is naturally ignored while busy.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_addr  = waddr;
        mem_wdata = wdata;
        mem_be    = be;
        rd_en     = 1'b0;
        unique case (state_q)
            StInit: begin
                if (INIT_CLEAR != 0) begin
                    mem_we    = 1'b1;
                    mem_addr  = cnt_q;
                    mem_wdata = '0;
                    mem_be    = '1;
                    cnt_d     = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_d = StRun;
                    end
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                mem_we = we;
                rd_en  = re;
            end
        endcase
    end

    // Write-first mode merges the enabled bytes of a colliding write into the read word.
    always_comb begin
        rd_word = mem[raddr];
        if ((RDW_MODE != 0) && mem_we && (mem_addr == raddr)) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    rd_word[8*i +: 8] = mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StInit;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rd_en;
            if (rd_en) begin
                rdata_q <= rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] rdata_p_q;
        logic                  rvalid_p_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_p_q  <= '0;
                rvalid_p_q <= 1'b0;
            end else begin
                rvalid_p_q <= rvalid_q;
                if (rvalid_q) begin
                    rdata_p_q <= rdata_q;
                end
            end
        end

        assign rdata  = rdata_p_q;
        assign rvalid = rvalid_p_q;
    end else begin : g_no_out_reg
        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end

    assign busy = (state_q == StInit);

endmodule

// File: doc/dual_port_ram.md
# dual_port_ram

Parametrised simple dual-port RAM: one synchronous write port and one independent synchronous read port on a single clock, with byte-enable writes, a selectable read-during-write mode, an optional output pipeline register and a post-reset memory-clear state machine. It replaces the fixed 8x64 single-port RAM wherever a design needs concurrent read and write access, wider words or a known memory state after reset.

## Interface
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 6: address width; DEPTH = 2**ADDR_WIDTH words.
- RDW_MODE, 0: same-address read during write. 0 = old data (read-first); 1 = new data (write-first, byte-merged).
- OUT_REG, 0: 1 adds an output register stage, increasing read latency by one.
- INIT_CLEAR, 1: 1 zero-fills the whole array after every reset.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- waddr  in  ADDR_WIDTH  write address.
- wdata  in  DATA_WIDTH  write data.
- be  in  DATA_WIDTH/8  byte enables; bit i gates wdata[8i+7:8i].
- re  in  1  read enable.
- raddr  in  ADDR_WIDTH  read address.
- rdata  out  DATA_WIDTH  read data.
- rvalid  out  1  rdata holds the result of a read this cycle.
- busy  out  1  init clear in progress; we/re ignored.

## Operation
- FSM states: INIT, RUN.
- While rst_n is low: state INIT, clear counter = 0, busy = 1, rdata = 0, rvalid = 0, pipeline registers = 0. The array itself is not reset asynchronously.
- INIT with INIT_CLEAR=1: each cycle writes 0 to mem[cnt], with all bytes enabled, then increments cnt. After writing cnt == DEPTH-1, the FSM moves to RUN. busy is high for exactly DEPTH cycles after rst_n rises.
- INIT with INIT_CLEAR=0: the FSM moves to RUN on the first edge after reset. busy falls after 1 cycle. Array contents are undefined.
- INIT also ignores we and re. No user writes occur, rvalid stays 0 and rdata holds 0.
- RUN write: if we=1, each byte i with be[i]=1 is written to mem[waddr]. Bytes with be[i]=0 keep their value. we=1 with be=0 is a no-op.
- RUN read: if re=1, mem[raddr] is captured into the read register. If re=0, the read register holds and rvalid deasserts on the corresponding cycle.
- Read and write to the same address in the same cycle:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the new word, with enabled bytes taken from wdata and the rest from the old word.
- Reads and writes to different addresses are fully independent.
- rdata keeps its last read value until the next read completes; it is never cleared except by reset.
- Asserting rst_n low at any time, including mid-INIT or mid-read, aborts immediately. Outputs go to their reset values and INIT restarts from address 0. Any in-flight read is discarded, with no rvalid.

## Timing
- Write: takes effect at the edge where we=1. A read of that address issued in the next cycle returns the new data in either mode.
- Read latency, OUT_REG=0: re/raddr sampled at edge N; rdata and rvalid are valid after edge N (cycle N+1). rvalid = 1 for one cycle per read.
- Read latency, OUT_REG=1: data valid after edge N+1. rvalid is delayed by the same stage.
- Back-to-back reads: one result per cycle, in order, with no bubbles.
- The first accepted access is in the cycle busy is low.

## Test plan
- Init: release rst_n, ADDR_WIDTH=6 -> busy high exactly 64 cycles. Reading every address afterwards returns 0 and rvalid pulses once per read.
- Basic write/read: write 32'h01, 32'h02, 32'h03 to addresses 0, 1, 2, then read 0, 1, 2 -> 32'h01, 32'h02, 32'h03 at latency 1 (OUT_REG=0) and latency 2 (OUT_REG=1).
- Byte enables: write 32'hAABBCCDD to address 5 with be=4'hF, then 32'h11223344 with be=4'b0101 -> read of address 5 returns 32'hAA22CC44.
- Read-during-write: address 7 holds 32'h0, then write 32'hFFFF0000 with be=4'b1100 while reading address 7 -> RDW_MODE=0 returns 32'h0; RDW_MODE=1 returns 32'hFFFF0000.
- Ignore during busy: pulse we=1 to address 3 with 32'hDEAD and re=1 during INIT -> rvalid stays 0 and address 3 reads 0 after busy falls.
- Mid-operation reset: drop rst_n during a read and again at init cycle 20 -> rdata=0, rvalid=0 and busy=1 immediately. After release, busy lasts a full 64 cycles and all addresses read 0.
